// File: rtl/sync_counter_pkg.sv
// Shared BCD constants and helpers for the synchronized BCD counter.
package sync_counter_pkg;
    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Non-decimal nibbles (A-F) are forced to zero on load.
    function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MIN : d;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: up/down step with ripple carry/borrow and synchronous load.
module bcd_digit
    import sync_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    input  logic             i_up,
    input  logic             i_cin,
    output logic [BCD_W-1:0] o_val,
    output logic             o_cout
);
    logic [BCD_W-1:0] r_val;
    logic             w_lim;

    // At the wrap point for the current direction, a step passes on to the next digit.
    assign w_lim  = i_up ? (r_val == BCD_MAX) : (r_val == BCD_MIN);
    assign o_cout = i_cin & w_lim;
    assign o_val  = r_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= BCD_MIN;
        end else if (i_load) begin
            r_val <= bcd_sanitize(i_load_val);
        end else if (i_cin) begin
            if (w_lim)
                r_val <= i_up ? BCD_MIN : BCD_MAX;
            else
                r_val <= i_up ? (r_val + 4'd1) : (r_val - 4'd1);
        end
    end
endmodule

// File: rtl/sync_bcd_counter.sv
// Multi-digit BCD up/down counter stepped by rising edges of a slow clock
// that is synchronized and sampled as data in the clk domain.
module sync_bcd_counter
    import sync_counter_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    slow_clk,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    step,
    output logic                    tc
);
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [SYNC_STAGES-1:0]  r_fill;
    logic                    r_prev;
    logic                    r_armed;
    logic                    r_step;
    logic                    r_tc;
    logic                    w_sync;
    logic                    w_valid;
    logic                    w_edge;
    logic                    w_step_en;
    logic [DIGITS:0]         w_carry;
    logic [BCD_W*DIGITS-1:0] w_count;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    // r_fill marks when the chain holds real samples rather than reset zeros,
    // so the reset value cannot arm the detector on its own.
    assign w_valid = r_fill[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_step  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], slow_clk};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev <= w_sync;
            if (w_valid && !w_sync)
                r_armed <= 1'b1;
            r_step <= w_step_en;
            r_tc   <= w_carry[DIGITS];
        end
    end

    assign w_edge     = r_armed & w_sync & ~r_prev;
    assign w_step_en  = w_edge & en & ~load;
    assign w_carry[0] = w_step_en;

    // Carry out of the top digit is exactly the full-count wrap.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_load    (load),
            .i_load_val(load_val[g*BCD_W +: BCD_W]),
            .i_up      (up),
            .i_cin     (w_carry[g]),
            .o_val     (w_count[g*BCD_W +: BCD_W]),
            .o_cout    (w_carry[g+1])
        );
    end

    assign count = w_count;
    assign step  = r_step;
    assign tc    = r_tc;
endmodule

// File: tb/tb_sync_bcd_counter.sv
// Directed bench for sync_bcd_counter (DIGITS=4, SYNC_STAGES=2).
module tb_sync_bcd_counter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        slow_clk;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        step;
    logic        tc;

    int n_assert = 0;
    int n_fail   = 0;
    int n_step   = 0;
    int n_tc     = 0;
    int s0, t0;

    sync_bcd_counter #(.DIGITS(4), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .slow_clk(slow_clk),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .step    (step),
        .tc      (tc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step) n_step++;
        if (tc)   n_tc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic period();
        slow_clk = 1'b1;
        repeat (4) @(negedge clk);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; slow_clk = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        repeat (3) @(negedge clk);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_step", 32'(step), 32'h0);
        chk("reset_tc", 32'(tc), 32'h0);

        // 12 periods counting up
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b1;
        s0 = n_step; t0 = n_tc;
        repeat (12) period();
        chk("up12_count", 32'(count), 32'h0012);
        chk("up12_steps", 32'(n_step - s0), 32'd12);
        chk("up12_tc", 32'(n_tc - t0), 32'd0);

        // wrap up 9999 -> 0000
        do_load(16'h9998);
        chk("load9998", 32'(count), 32'h9998);
        s0 = n_step; t0 = n_tc;
        period();
        chk("up_9999", 32'(count), 32'h9999);
        chk("up_9999_tc", 32'(n_tc - t0), 32'd0);
        t0 = n_tc;
        period();
        chk("up_wrap", 32'(count), 32'h0000);
        chk("up_wrap_tc", 32'(n_tc - t0), 32'd1);
        chk("up_wrap_steps", 32'(n_step - s0), 32'd2);

        // wrap down 0000 -> 9999
        do_load(16'h0001);
        up = 1'b0;
        t0 = n_tc;
        period();
        chk("dn_0000", 32'(count), 32'h0000);
        chk("dn_0000_tc", 32'(n_tc - t0), 32'd0);
        t0 = n_tc;
        period();
        chk("dn_wrap", 32'(count), 32'h9999);
        chk("dn_wrap_tc", 32'(n_tc - t0), 32'd1);

        // load coincident with the detected edge; nibbles A and F load as 0
        up = 1'b1;
        s0 = n_step; t0 = n_tc;
        slow_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load = 1'b1; load_val = 16'h3A7F;
        @(negedge clk);
        load = 1'b0;
        chk("ld_edge_count", 32'(count), 32'h3070);
        chk("ld_edge_step", 32'(step), 32'h0);
        chk("ld_edge_tc", 32'(tc), 32'h0);
        repeat (2) @(negedge clk);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        chk("ld_edge_nostep", 32'(n_step - s0), 32'd0);
        chk("ld_edge_hold", 32'(count), 32'h3070);

        // slow_clk high across reset release: no spurious step
        slow_clk = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi_count", 32'(count), 32'h0);
        s0 = n_step;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arm_nostep", 32'(n_step - s0), 32'd0);
        chk("arm_count", 32'(count), 32'h0);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        period();
        chk("arm_one_step", 32'(n_step - s0), 32'd1);
        chk("arm_count1", 32'(count), 32'h0001);

        // en=0 discards edges
        en = 1'b0;
        s0 = n_step;
        repeat (5) period();
        chk("en0_count", 32'(count), 32'h0001);
        chk("en0_steps", 32'(n_step - s0), 32'd0);
        en = 1'b1;
        repeat (2) period();
        chk("en1_count", 32'(count), 32'h0003);

        // partial-cycle reset with an edge in flight
        s0 = n_step;
        slow_clk = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_step", 32'(step), 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        repeat (6) @(negedge clk);
        chk("midrst_nostep", 32'(n_step - s0), 32'd0);
        chk("midrst_hold", 32'(count), 32'h0);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        period();
        chk("rearm_step", 32'(n_step - s0), 32'd1);
        chk("rearm_count", 32'(count), 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_bcd_counter.md
SYNC_BCD_COUNTER -- requirements
Module: sync_bcd_counter

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, giving the number of BCD digits (range 1-8).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, giving the synchronizer depth for slow_clk (range 2-4).
REQ-003 SHALL provide port clk  in  1  system clock (100 MHz); the only clock in the block.
REQ-004 SHALL provide port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port slow_clk  in  1  divided clock from the clock divider; sampled as data, never used as a clock.
REQ-006 SHALL provide port en  in  1  count enable; steps are taken only while high.
REQ-007 SHALL provide port up  in  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL provide port load  in  1  synchronous load strobe.
REQ-009 SHALL provide port load_val  in  4*DIGITS  BCD value to load, with digit 0 in bits [3:0].
REQ-010 SHALL provide port count  out  4*DIGITS  current BCD count.
REQ-011 SHALL provide port step  out  1  one-clk pulse in the cycle after count changed due to a slow_clk edge.
REQ-012 SHALL provide port tc  out  1  one-clk pulse coincident with step when that step wrapped the full count.

Function
REQ-013 SHALL pass slow_clk through a SYNC_STAGES flip-flop chain clocked by clk before any use.
REQ-014 SHALL detect a rising edge as synchronized=1 and previous synchronized=0, giving one edge per slow_clk period.
REQ-015 SHALL ignore all edges until the synchronized slow_clk has been sampled low at least once since reset release (arming); this prevents a spurious step when slow_clk is high at reset release.
REQ-016 SHALL, for a detected edge with en=1 and load=0, update count on the next clk edge; latency from a slow_clk rise at the port to the count change is SYNC_STAGES+1 clk edges.
REQ-017 SHALL, when up=1, increment digit 0; a digit at 9 becomes 0 and carries into the next digit.
REQ-018 SHALL, when up=0, decrement digit 0; a digit at 0 becomes 9 and borrows from the next digit.
REQ-019 SHALL wrap the full count from all-9s to all-0s (up) or from all-0s to all-9s (down), asserting tc for that step.
REQ-020 SHALL give load priority over a detected edge: count := load_val on the next clk edge, the edge is discarded, and step=0, tc=0.
REQ-021 SHALL load any load_val digit greater than 9 as 0; other digits load unchanged.
REQ-022 SHALL discard edges detected while en=0 (no deferred counting); count holds, step=0, tc=0.
REQ-023 SHALL register step and tc, so each is high for exactly one clk cycle per counted edge.
REQ-024 SHALL sample up in the same cycle as the edge detection; a direction change takes effect on the next counted edge.

Reset
REQ-025 SHALL, while rst_n=0, force count=0, step=0, tc=0, all synchronizer and edge registers to 0, and the arming flag to 0, independent of clk.
REQ-026 SHALL discard any edge in flight when reset is asserted mid-operation; counting restarts from 0 after re-arming.
REQ-027 SHALL use the external reset synchronizer for deassertion; no internal reset synchronizer is required.

Structure
REQ-028 SHALL place the constants BCD_W=4, BCD_MAX=4'd9 and BCD_MIN=4'd0 in the shared package sync_counter_pkg.
REQ-029 SHALL implement one BCD digit (value, up/down, carry/borrow in, carry/borrow out, load) as sub-module bcd_digit, instantiated DIGITS times in a generate loop with a ripple carry chain.
REQ-030 SHALL implement the synchronizer, arming flag, edge detect, and step/tc registers in the top module.

Verification
REQ-031 SHALL cover this scenario: with DIGITS=4, reset then up=1, en=1 and 12 slow_clk periods -> count=0x0012, 12 step pulses, no tc.
REQ-032 SHALL cover this scenario: load 0x9998, up=1, 2 edges -> count 0x9999 then 0x0000, with tc on the second step only.
REQ-033 SHALL cover this scenario: load 0x0001, up=0, 2 edges -> count 0x0000 then 0x9999, with tc on the second step.
REQ-034 SHALL cover this scenario: load=1 with load_val=0x3A7F in the edge-detect cycle -> count=0x3070, step=0, tc=0.
REQ-035 SHALL cover this scenario: slow_clk held high across reset release, then 1 full period -> exactly 1 step and count=0x0001; en=0 for 5 periods -> count unchanged.
REQ-036 SHALL cover this scenario: assert rst_n=0 for a partial clk cycle mid-count -> count=0 immediately, with no step pulse after release until re-armed.
